// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline memory-stage control logic:
// control-bundle bit positions, bundle width, FSM encoding and small
// helpers for decoding the control bundle.
package pipe_ctrl_pkg;

    // Width of the control bundle carried down the pipeline
    localparam int CTRL_W = 12;

    // Bit positions inside the control bundle
    localparam int CTRL_MEM_WE = 0;
    localparam int CTRL_MEM_RE = 1;
    localparam int CTRL_REG_WE = 2;

    // Memory-stage controller states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // True when the bundle asks for any data-memory access
    function automatic logic is_mem_op(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_WE] | ctrl[CTRL_MEM_RE];
    endfunction

    // Stores win when both access bits are set
    function automatic logic is_store(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_WE];
    endfunction

    // Bundle with the register write-back suppressed
    function automatic logic [CTRL_W-1:0] kill_reg_we(input logic [CTRL_W-1:0] ctrl);
        logic [CTRL_W-1:0] r;
        r = ctrl;
        r[CTRL_REG_WE] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for a memory access. Cleared when an access starts,
// counts every enabled cycle, and flags the cycle in which the count
// reaches MAX_WAIT. Usable on either the data or instruction memory side.
module mem_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles, saturating at MAX_WAIT until the next clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(MAX_WAIT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires in the enabled cycle whose increment brings the count to MAX_WAIT,
    // so exactly MAX_WAIT enabled cycles elapse before expiry takes effect
    assign expired = enable && !clear && (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller. Takes the execute/memory latch outputs, runs
// loads and stores against a multi-cycle data memory, stalls the front of
// the pipeline while an access is outstanding, and presents registered,
// valid-tagged results to the memory/writeback latch.
//
// Memory handshake: dmem_req is registered and stays high, together with
// stable dmem_we/dmem_addr/dmem_wdata, until the memory answers. dmem_ack is
// a single-cycle pulse; the access completes in the cycle where dmem_req=1
// and dmem_ack=1, and dmem_rdata is only looked at in that cycle. An ack seen
// while no request is outstanding is ignored. If MAX_WAIT request cycles pass
// without ack the access is abandoned and reported through mem_err.
module mem_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    // execute/memory latch
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_PC_next,
    input  logic [DATA_W-1:0] in_ALU_result,
    input  logic [DATA_W-1:0] in_data_reg,
    input  logic [CTRL_W-1:0] in_ctrl_signals,
    input  logic [4:0]        in_rd,
    // data memory
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    // pipeline control
    output logic              stall,
    // memory/writeback latch
    output logic              out_valid,
    output logic [DATA_W-1:0] out_PC_next,
    output logic [DATA_W-1:0] out_ALU_result,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [CTRL_W-1:0] out_ctrl_signals,
    output logic [4:0]        out_rd,
    output logic              mem_err,
    // observability
    output state_t            dbg_state
);

    state_t            state;

    // Bundle held for the instruction whose access is in flight; the
    // address and store data live directly in dmem_addr / dmem_wdata
    logic [DATA_W-1:0] cap_pc;
    logic [CTRL_W-1:0] cap_ctrl;
    logic [4:0]        cap_rd;

    logic in_mem_op;
    logic busy;
    logic start;
    logic ack_done;
    logic timeout;
    logic done;

    assign in_mem_op = in_valid && is_mem_op(in_ctrl_signals);
    assign busy      = (state == BUSY);
    assign start     = !busy && in_mem_op;
    assign ack_done  = busy && dmem_ack;
    assign done      = ack_done || timeout;
    assign dbg_state = state;

    // Hold the XM latch while an access is being launched or is still
    // waiting; release it in the completing cycle so the next instruction
    // is presented in the first IDLE cycle. Forced low while in reset.
    assign stall = reset && (start || (busy && !done));

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (start),
        .enable  (busy && !dmem_ack),
        .expired (timeout)
    );

    // IDLE/BUSY controller with registered memory request and result bundle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            cap_pc           <= '0;
            cap_ctrl         <= '0;
            cap_rd           <= '0;
            out_valid        <= 1'b0;
            out_PC_next      <= '0;
            out_ALU_result   <= '0;
            out_mem_data     <= '0;
            out_ctrl_signals <= '0;
            out_rd           <= '0;
            mem_err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Launch the access; a bubble goes downstream meanwhile
                        state      <= BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store(in_ctrl_signals);
                        dmem_addr  <= in_ALU_result;
                        dmem_wdata <= in_data_reg;
                        cap_pc     <= in_PC_next;
                        cap_ctrl   <= in_ctrl_signals;
                        cap_rd     <= in_rd;
                        out_valid  <= 1'b0;
                    end else if (in_valid) begin
                        // Non-memory instruction passes straight through
                        out_valid        <= 1'b1;
                        out_PC_next      <= in_PC_next;
                        out_ALU_result   <= in_ALU_result;
                        out_mem_data     <= '0;
                        out_ctrl_signals <= in_ctrl_signals;
                        out_rd           <= in_rd;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end

                BUSY: begin
                    if (done) begin
                        state          <= IDLE;
                        dmem_req       <= 1'b0;
                        out_valid      <= 1'b1;
                        out_PC_next    <= cap_pc;
                        out_ALU_result <= dmem_addr;
                        out_rd         <= cap_rd;
                        if (ack_done) begin
                            // Normal completion; ack wins over a same-cycle limit
                            out_mem_data     <= dmem_we ? '0 : dmem_rdata;
                            out_ctrl_signals <= cap_ctrl;
                        end else begin
                            // Abandoned access: no data, no register write-back
                            out_mem_data     <= '0;
                            out_ctrl_signals <= kill_reg_we(cap_ctrl);
                            mem_err          <= 1'b1;
                        end
                    end else begin
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
